// File: rtl/bv_pkg.sv
// Shared types and helpers for the bit-vector checker.
package bv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FAIL = 2'd2
   } bv_state_e;

   // Width needed to hold a popcount of 0..w without truncation.
   function automatic int unsigned ones_w(input int unsigned w);
      return $clog2(w + 1);
   endfunction

   // Saturating increment of a w-bit counter carried in 32 bits (w <= 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] max_v;
      max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      return (v >= max_v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/bv_popcount.sv
// Combinational population count at full width.
module bv_popcount
   import bv_pkg::*;
#(
   parameter int unsigned WIDTH = 2
) (
   input  logic [WIDTH-1:0]          data,
   output logic [ones_w(WIDTH)-1:0]  count
);

   localparam int unsigned OW = ones_w(WIDTH);

   // Sum of all set bits.
   always_comb begin
      count = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         count = count + OW'(data[i]);
      end
   end

endmodule

// File: rtl/bv_checker.sv
// Sampled bit-vector checker: popcount/onehot flags, sticky ones-limit error,
// first-failure index and saturating sample/violation counters.
module bv_checker
   import bv_pkg::*;
#(
   parameter int unsigned WIDTH    = 2,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned MAX_ONES = 1
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      en,
   input  logic                      clear,
   input  logic [WIDTH-1:0]          data,
   output logic [ones_w(WIDTH)-1:0]  ones,
   output logic                      onehot,
   output logic                      onehot0,
   output logic                      err,
   output logic [CNT_W-1:0]          err_idx,
   output logic [CNT_W-1:0]          viol_cnt,
   output logic [CNT_W-1:0]          smp_cnt,
   output logic                      busy
);

   localparam int unsigned OW = ones_w(WIDTH);

   bv_state_e        state_q, state_d;
   logic [OW-1:0]    cnt_c;
   logic             viol_c;
   logic [OW-1:0]    ones_d;
   logic             onehot_d, onehot0_d, err_d;
   logic [CNT_W-1:0] err_idx_d, viol_cnt_d, smp_cnt_d;

   bv_popcount #(.WIDTH(WIDTH)) u_popcount (
      .data  (data),
      .count (cnt_c)
   );

   // Unsigned limit check on the full-width popcount.
   assign viol_c = 32'(cnt_c) > MAX_ONES;

   // Next-state and next-output logic; clear beats a same-cycle sample.
   always_comb begin
      state_d    = state_q;
      ones_d     = ones;
      onehot_d   = onehot;
      onehot0_d  = onehot0;
      err_d      = err;
      err_idx_d  = err_idx;
      viol_cnt_d = viol_cnt;
      smp_cnt_d  = smp_cnt;
      if (clear) begin
         state_d    = IDLE;
         ones_d     = '0;
         onehot_d   = 1'b0;
         onehot0_d  = 1'b1;
         err_d      = 1'b0;
         err_idx_d  = '0;
         viol_cnt_d = '0;
         smp_cnt_d  = '0;
      end else if (en) begin
         ones_d    = cnt_c;
         onehot_d  = (cnt_c == OW'(1));
         onehot0_d = (cnt_c <= OW'(1));
         smp_cnt_d = CNT_W'(sat_inc(32'(smp_cnt), CNT_W));
         if (viol_c) begin
            viol_cnt_d = CNT_W'(sat_inc(32'(viol_cnt), CNT_W));
            if (!err) begin
               err_d     = 1'b1;
               err_idx_d = smp_cnt;
            end
         end
         case (state_q)
            IDLE:    state_d = viol_c ? FAIL : RUN;
            RUN:     state_d = viol_c ? FAIL : RUN;
            FAIL:    state_d = FAIL;
            default: state_d = IDLE;
         endcase
      end
   end

   // State, flag and counter registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= IDLE;
         ones     <= '0;
         onehot   <= 1'b0;
         onehot0  <= 1'b1;
         err      <= 1'b0;
         err_idx  <= '0;
         viol_cnt <= '0;
         smp_cnt  <= '0;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         ones     <= ones_d;
         onehot   <= onehot_d;
         onehot0  <= onehot0_d;
         err      <= err_d;
         err_idx  <= err_idx_d;
         viol_cnt <= viol_cnt_d;
         smp_cnt  <= smp_cnt_d;
         busy     <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_bv_checker.sv
// Directed bench for bv_checker: vector table plus multi-cycle sequences.
module tb_bv_checker;

   logic       clk = 1'b0;
   logic       rstn, en, clear;
   logic [1:0] data;

   // u0: defaults (WIDTH=2, CNT_W=8, MAX_ONES=1)
   logic [1:0] ones0;
   logic       oh0, oh00, err0, busy0;
   logic [7:0] idx0, viol0, smp0;
   // u1: MAX_ONES=0
   logic [1:0] ones1;
   logic       oh1, oh01, err1, busy1;
   logic [7:0] idx1, viol1, smp1;
   // u2: CNT_W=4
   logic [1:0] ones2;
   logic       oh2, oh02, err2, busy2;
   logic [3:0] idx2, viol2, smp2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   bv_checker #(.WIDTH(2), .CNT_W(8), .MAX_ONES(1)) u0 (
      .clk(clk), .rstn(rstn), .en(en), .clear(clear), .data(data),
      .ones(ones0), .onehot(oh0), .onehot0(oh00), .err(err0),
      .err_idx(idx0), .viol_cnt(viol0), .smp_cnt(smp0), .busy(busy0));

   bv_checker #(.WIDTH(2), .CNT_W(8), .MAX_ONES(0)) u1 (
      .clk(clk), .rstn(rstn), .en(en), .clear(clear), .data(data),
      .ones(ones1), .onehot(oh1), .onehot0(oh01), .err(err1),
      .err_idx(idx1), .viol_cnt(viol1), .smp_cnt(smp1), .busy(busy1));

   bv_checker #(.WIDTH(2), .CNT_W(4), .MAX_ONES(1)) u2 (
      .clk(clk), .rstn(rstn), .en(en), .clear(clear), .data(data),
      .ones(ones2), .onehot(oh2), .onehot0(oh02), .err(err2),
      .err_idx(idx2), .viol_cnt(viol2), .smp_cnt(smp2), .busy(busy2));

   typedef struct {
      logic       en;
      logic       clr;
      logic [1:0] d;
      int         ones, oh, oh0, err, idx, viol, smp, busy;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Apply inputs before an edge, then sample just after it.
   task automatic step(input logic r, input logic e, input logic c, input logic [1:0] d);
      @(negedge clk);
      rstn  = r;
      en    = e;
      clear = c;
      data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_u0(input string tag, input vec_t v);
      chk({tag, ".ones"},     int'(ones0), v.ones);
      chk({tag, ".onehot"},   int'(oh0),   v.oh);
      chk({tag, ".onehot0"},  int'(oh00),  v.oh0);
      chk({tag, ".err"},      int'(err0),  v.err);
      chk({tag, ".err_idx"},  int'(idx0),  v.idx);
      chk({tag, ".viol_cnt"}, int'(viol0), v.viol);
      chk({tag, ".smp_cnt"},  int'(smp0),  v.smp);
      chk({tag, ".busy"},     int'(busy0), v.busy);
   endtask

   vec_t rst_v;

   initial begin
      rstn = 1'b0; en = 1'b0; clear = 1'b0; data = 2'd0;
      rst_v = '{1'b0, 1'b0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0};

      // Reset state on all instances.
      step(1'b0, 1'b1, 1'b0, 2'd3);
      step(1'b0, 1'b0, 1'b0, 2'd0);
      chk_u0("reset", rst_v);
      chk("reset.u1.onehot0", int'(oh01), 1);
      chk("reset.u2.smp_cnt", int'(smp2), 0);

      //                en    clr   d     ones oh oh0 err idx viol smp busy
      vecs.push_back('{1'b1, 1'b0, 2'd1, 1, 1, 1, 0, 0, 0, 1, 1});
      vecs.push_back('{1'b1, 1'b0, 2'd2, 1, 1, 1, 0, 0, 0, 2, 1});
      vecs.push_back('{1'b1, 1'b0, 2'd1, 1, 1, 1, 0, 0, 0, 3, 1});
      vecs.push_back('{1'b1, 1'b0, 2'd1, 1, 1, 1, 0, 0, 0, 4, 1});
      vecs.push_back('{1'b1, 1'b0, 2'd2, 1, 1, 1, 0, 0, 0, 5, 1});
      vecs.push_back('{1'b1, 1'b0, 2'd2, 1, 1, 1, 0, 0, 0, 6, 1});
      vecs.push_back('{1'b0, 1'b0, 2'd3, 1, 1, 1, 0, 0, 0, 6, 1});
      vecs.push_back('{1'b0, 1'b1, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0});
      vecs.push_back('{1'b1, 1'b0, 2'd1, 1, 1, 1, 0, 0, 0, 1, 1});
      vecs.push_back('{1'b1, 1'b0, 2'd2, 1, 1, 1, 0, 0, 0, 2, 1});
      vecs.push_back('{1'b1, 1'b0, 2'd3, 2, 0, 0, 1, 2, 1, 3, 1});
      vecs.push_back('{1'b1, 1'b0, 2'd0, 0, 0, 1, 1, 2, 1, 4, 1});
      vecs.push_back('{1'b1, 1'b0, 2'd3, 2, 0, 0, 1, 2, 2, 5, 1});
      vecs.push_back('{1'b0, 1'b0, 2'd3, 2, 0, 0, 1, 2, 2, 5, 1});
      vecs.push_back('{1'b1, 1'b1, 2'd3, 0, 0, 1, 0, 0, 0, 0, 0});
      vecs.push_back('{1'b1, 1'b0, 2'd0, 0, 0, 1, 0, 0, 0, 1, 1});

      foreach (vecs[i]) begin
         step(1'b1, vecs[i].en, vecs[i].clr, vecs[i].d);
         chk_u0($sformatf("vec%0d", i), vecs[i]);
      end

      // 20 all-zero samples.
      step(1'b1, 1'b0, 1'b1, 2'd0);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 2'd0);
      chk_u0("zeros20", '{1'b0, 1'b0, 2'd0, 0, 0, 1, 0, 0, 0, 20, 1});

      // MAX_ONES=0: single 1 at sample index 18.
      step(1'b1, 1'b0, 1'b1, 2'd0);
      for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 1'b0, 2'd0);
      chk("max0.pre.err", int'(err1), 0);
      step(1'b1, 1'b1, 1'b0, 2'd1);
      step(1'b1, 1'b1, 1'b0, 2'd0);
      chk("max0.err",      int'(err1),  1);
      chk("max0.err_idx",  int'(idx1),  18);
      chk("max0.viol_cnt", int'(viol1), 1);
      chk("max0.smp_cnt",  int'(smp1),  20);

      // CNT_W=4: 20 violating samples saturate at 15.
      step(1'b1, 1'b0, 1'b1, 2'd0);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 1'b0, 2'd3);
         chk($sformatf("sat.smp%0d", i), int'(smp2), (i + 1 > 15) ? 15 : i + 1);
      end
      chk("sat.viol_cnt", int'(viol2), 15);
      chk("sat.err_idx",  int'(idx2),  0);
      chk("sat.err",      int'(err2),  1);

      // CNT_W=4: first violation after smp_cnt saturates records 15.
      step(1'b1, 1'b0, 1'b1, 2'd0);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 2'd1);
      chk("satidx.pre.err", int'(err2), 0);
      step(1'b1, 1'b1, 1'b0, 2'd3);
      chk("satidx.err_idx",  int'(idx2),  15);
      chk("satidx.viol_cnt", int'(viol2), 1);
      chk("satidx.smp_cnt",  int'(smp2),  15);

      // Reset mid-stream with en high, then resume counting from 0.
      step(1'b1, 1'b0, 1'b1, 2'd0);
      step(1'b1, 1'b1, 1'b0, 2'd3);
      step(1'b1, 1'b1, 1'b0, 2'd1);
      step(1'b0, 1'b1, 1'b1, 2'd3);
      chk_u0("midrst", rst_v);
      step(1'b1, 1'b1, 1'b0, 2'd2);
      chk_u0("resume", '{1'b1, 1'b0, 2'd2, 1, 1, 1, 0, 0, 0, 1, 1});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
